// File: rtl/rdi_pkg.sv
// rdi_pkg: state encoding and defaults shared by the RDI stall logic.
package rdi_pkg;
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam int FLIT_BEATS_DEF = 4;
endpackage

// File: rtl/rdi_flit_beat_counter.sv
// rdi_flit_beat_counter: counts completed beats within a flit and flags flit boundaries.
module rdi_flit_beat_counter #(
   parameter int FLIT_BEATS = 4,
   parameter int CNT_W      = $clog2(FLIT_BEATS)
) (
   input  logic             lclk,
   input  logic             sys_rst,
   input  logic             xfer_i,
   output logic [CNT_W-1:0] beat_cnt_o,
   output logic             at_boundary_o,
   output logic             last_beat_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      last_beat_o   = cnt_q == CNT_W'(FLIT_BEATS - 1);
      at_boundary_o = cnt_q == '0;
      beat_cnt_o    = cnt_q;
      cnt_d         = xfer_i ? (last_beat_o ? '0 : cnt_q + 1'b1) : cnt_q;
   end
   always_ff @(posedge lclk) begin
      if (sys_rst) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/rdi_stall_responder.sv
// rdi_stall_responder: drains the in-flight flit on a PHY stall request, then
// acknowledges and holds transmit gated until the request is withdrawn.
module rdi_stall_responder import rdi_pkg::*; #(
   parameter int FLIT_BEATS = FLIT_BEATS_DEF,
   parameter int CNT_W      = $clog2(FLIT_BEATS)
) (
   input  logic lclk,
   input  logic sys_rst,
   input  logic i_pl_stallreq,
   input  logic i_pl_trdy,
   input  logic i_tx_valid,
   output logic o_tx_ready,
   output logic o_lp_valid,
   output logic o_lp_irdy,
   output logic o_lp_stallack,
   output logic o_stall_active,
   output logic o_stall_abort
);
   logic [1:0]       state_q, state_d;
   logic             stallack_d, abort_d;
   logic             gate, xfer, at_boundary, last_beat;
   logic [CNT_W-1:0] beat_cnt;
   rdi_flit_beat_counter #(.FLIT_BEATS(FLIT_BEATS), .CNT_W(CNT_W)) u_cnt (
      .lclk          (lclk),
      .sys_rst       (sys_rst),
      .xfer_i        (xfer),
      .beat_cnt_o    (beat_cnt),
      .at_boundary_o (at_boundary),
      .last_beat_o   (last_beat)
   );
   always_ff @(posedge lclk) begin
      if (sys_rst) begin
         state_q       <= ST_RUN;
         o_lp_stallack <= 1'b0;
         o_stall_abort <= 1'b0;
      end else begin
         state_q       <= state_d;
         o_lp_stallack <= stallack_d;
         o_stall_abort <= abort_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN)
         state_d = i_pl_stallreq ? (at_boundary ? ST_ACK : ST_DRAIN) : ST_RUN;
      else if (state_q == ST_DRAIN)
         state_d = (xfer && last_beat) ? (i_pl_stallreq ? ST_ACK : ST_RUN) : ST_DRAIN;
      else
         state_d = i_pl_stallreq ? ST_ACK : ST_RUN;
   end
   // Gating at a boundary is combinational so no flit starts in the request cycle.
   always_comb begin
      gate           = (state_q == ST_ACK) || (state_q == ST_RUN && i_pl_stallreq && at_boundary);
      o_lp_valid     = i_tx_valid && !gate;
      o_lp_irdy      = o_lp_valid;
      xfer           = o_lp_valid && i_pl_trdy;
      o_tx_ready     = xfer;
      o_stall_active = (state_q == ST_DRAIN) || (state_q == ST_ACK);
      stallack_d     = state_d == ST_ACK;
      abort_d        = (state_q == ST_DRAIN) && xfer && last_beat && !i_pl_stallreq;
   end
   always_ff @(posedge lclk) begin
      if (!sys_rst && state_q == ST_ACK) assert (beat_cnt == '0);
      if (!sys_rst) assert (!(o_lp_stallack && o_lp_valid));
   end
endmodule

// File: tb/tb_rdi_stall_responder.sv
// tb_rdi_stall_responder: directed checks of the stall handshake with FLIT_BEATS=4.
module tb_rdi_stall_responder;
   logic lclk = 1'b0;
   logic sys_rst, i_pl_stallreq, i_pl_trdy, i_tx_valid;
   logic o_tx_ready, o_lp_valid, o_lp_irdy, o_lp_stallack, o_stall_active, o_stall_abort;
   int   checks = 0;
   int   failures = 0;
   int   viol = 0;
   int   beats, ack_at, ab_n, ab_at;
   always #5 lclk = ~lclk;
   rdi_stall_responder #(.FLIT_BEATS(4)) dut (
      .lclk           (lclk),
      .sys_rst        (sys_rst),
      .i_pl_stallreq  (i_pl_stallreq),
      .i_pl_trdy      (i_pl_trdy),
      .i_tx_valid     (i_tx_valid),
      .o_tx_ready     (o_tx_ready),
      .o_lp_valid     (o_lp_valid),
      .o_lp_irdy      (o_lp_irdy),
      .o_lp_stallack  (o_lp_stallack),
      .o_stall_active (o_stall_active),
      .o_stall_abort  (o_stall_abort)
   );
   always @(negedge lclk) if (o_lp_stallack && o_lp_valid) viol++;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic adv();
      @(posedge lclk);
      #1;
   endtask
   task automatic smp();
      @(negedge lclk);
   endtask
   // Runs n cycles: trdy low for the first tl, request high for the first rc.
   task automatic win(input int n, input int tl, input int rc);
      beats = 0; ack_at = -1; ab_n = 0; ab_at = -1;
      for (int i = 0; i < n; i++) begin
         i_pl_trdy = (i >= tl);
         i_pl_stallreq = (i < rc);
         smp();
         if (o_tx_ready) beats++;
         if (o_lp_stallack && ack_at < 0) ack_at = i;
         if (o_stall_abort) begin
            ab_n++;
            if (ab_at < 0) ab_at = i;
         end
         adv();
      end
   endtask
   initial begin
      sys_rst = 1'b1; i_tx_valid = 1'b1; i_pl_stallreq = 1'b1; i_pl_trdy = 1'b1;
      smp();
      chk("rst_ack", o_lp_stallack, 0);
      chk("rst_abort", o_stall_abort, 0);
      chk("rst_valid", o_lp_valid, 0);
      adv();
      sys_rst = 1'b0;
      smp();
      chk("post_rst_ack", o_lp_stallack, 0);
      chk("post_rst_valid", o_lp_valid, 0);
      adv();
      smp();
      chk("post_rst_ack_1cyc", o_lp_stallack, 1);
      chk("ack_active", o_stall_active, 1);
      adv();
      i_pl_stallreq = 1'b0; i_tx_valid = 1'b0;
      smp();
      chk("release_ack_hold", o_lp_stallack, 1);
      adv();
      smp();
      chk("release_ack_clr", o_lp_stallack, 0);
      chk("idle_inactive", o_stall_active, 0);
      adv();
      i_pl_stallreq = 1'b1; i_tx_valid = 1'b1;
      smp();
      chk("bnd_valid_n", o_lp_valid, 0);
      chk("bnd_ready_n", o_tx_ready, 0);
      chk("bnd_ack_n", o_lp_stallack, 0);
      adv();
      smp();
      chk("bnd_ack_n1", o_lp_stallack, 1);
      chk("bnd_valid_n1", o_lp_valid, 0);
      adv();
      smp();
      chk("bnd_ack_hold", o_lp_stallack, 1);
      adv();
      i_pl_stallreq = 1'b0;
      smp();
      chk("rel_m_ack", o_lp_stallack, 1);
      chk("rel_m_valid", o_lp_valid, 0);
      adv();
      smp();
      chk("rel_m1_ack", o_lp_stallack, 0);
      chk("rel_m1_valid", o_lp_valid, 1);
      chk("rel_m1_irdy", o_lp_irdy, 1);
      adv();
      win(6, 0, 99);
      chk("mid_beats", beats, 3);
      chk("mid_ack_at", ack_at, 3);
      chk("mid_abort", ab_n, 0);
      i_pl_stallreq = 1'b0; i_tx_valid = 1'b0;
      adv();
      adv();
      i_tx_valid = 1'b1;
      adv();
      adv();
      win(8, 3, 99);
      chk("bp_beats", beats, 2);
      chk("bp_ack_at", ack_at, 5);
      i_pl_stallreq = 1'b0; i_tx_valid = 1'b0;
      adv();
      adv();
      i_tx_valid = 1'b1;
      adv();
      win(8, 0, 1);
      chk("wd_beats", beats, 8);
      chk("wd_abort_n", ab_n, 1);
      chk("wd_abort_at", ab_at, 3);
      chk("wd_no_ack", ack_at, -1);
      i_pl_stallreq = 1'b1;
      adv();
      sys_rst = 1'b1;
      smp();
      chk("drain_valid", o_lp_valid, 1);
      chk("drain_active", o_stall_active, 1);
      adv();
      sys_rst = 1'b0;
      smp();
      chk("rstd_valid", o_lp_valid, 0);
      chk("rstd_ack", o_lp_stallack, 0);
      adv();
      smp();
      chk("rstd_ack_1cyc", o_lp_stallack, 1);
      chk("no_ack_with_valid", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rdi_stall_responder.md
# rdi_stall_responder

Adapter-side responder for the RDI stall handshake. It observes `i_pl_stallreq` from the physical layer, finishes any flit already in progress on the transmit path, and stops new flits from starting. It then asserts `o_lp_stallack` and holds it until the physical layer withdraws the request. The block sits between the adapter transmit scheduler and the RDI transmit interface and gates only the control signals; the data bus bypasses it.

## Interface
- `FLIT_BEATS`, default 4: RDI beats per flit (≥2).
- `CNT_W`, default `$clog2(FLIT_BEATS)`: width of the beat counter.

- `lclk`  in  1  local clock; all logic rises on its posedge.
- `sys_rst`  in  1  reset, synchronous and active-high.
- `i_pl_stallreq`  in  1  stall request from the physical layer.
- `i_pl_trdy`  in  1  physical layer accepts a beat.
- `i_tx_valid`  in  1  the upstream scheduler has a beat to send.
- `o_tx_ready`  out  1  beat accepted from upstream (`o_lp_valid & i_pl_trdy`).
- `o_lp_valid`  out  1  RDI transmit valid.
- `o_lp_irdy`  out  1  RDI transmit irdy, equal to `o_lp_valid`.
- `o_lp_stallack`  out  1  stall acknowledge. Registered.
- `o_stall_active`  out  1  high in DRAIN or ACK.
- `o_stall_abort`  out  1  one-cycle pulse when a request is withdrawn before it is acknowledged. Registered.

## Operation
- **States:** RUN, DRAIN, ACK. Reset state is RUN.
- **Beat counter:** `beat_cnt` counts completed transfers (`xfer = o_lp_valid & i_pl_trdy`). It wraps from FLIT_BEATS-1 to 0. A value of 0 means the interface is at a flit boundary.
- **Gate:** `gate = (state==ACK) | (state==RUN & i_pl_stallreq & beat_cnt==0)`.
- **Gated outputs:** `o_lp_valid = i_tx_valid & ~gate`. This is combinational, so a new flit never starts in the cycle a request is seen at a boundary.
- **RUN:**
  - If `i_pl_stallreq & beat_cnt==0`, go to ACK.
  - Else if `i_pl_stallreq`, go to DRAIN.
  - Otherwise stay in RUN.
- **DRAIN:** beats keep flowing. On the `xfer` that brings `beat_cnt` from FLIT_BEATS-1 to 0:
  - If `i_pl_stallreq` is still 1, go to ACK.
  - Otherwise go to RUN and pulse `o_stall_abort`.
- **DRAIN withdrawal:** if `i_pl_stallreq` drops mid-flit, the block still finishes the flit (it never truncates a flit) and then takes the abort path.
- **ACK:** `o_lp_stallack` is 1 and nothing is transferred. When `i_pl_stallreq==0`, go to RUN and clear `o_lp_stallack` on the same edge.
- **Re-request:** a new request after release is handled from RUN like any other request. The counter is at 0, so it is acknowledged immediately.
- **Reset values:** `o_lp_stallack=0`, `o_stall_abort=0`, `beat_cnt=0`, state RUN. `o_lp_valid` and `o_tx_ready` follow the combinational equations, so they are 0 unless `i_tx_valid` is high.
- **Reset mid-operation:** the block returns immediately to RUN with the counter cleared and stallack dropped. The partial flit is abandoned, and upstream must flush it.

## Timing
- **Request at a boundary:** request high in cycle N in RUN with `beat_cnt==0`.
  - Cycle N: no transfer.
  - Edge ending N: state ACK, `o_lp_stallack=1` from cycle N+1.
  - Acknowledge latency is 1 cycle.
- **Request mid-flit:** request high with `beat_cnt=k≠0` and `i_pl_trdy` and `i_tx_valid` held high.
  - FLIT_BEATS-k further beats transfer.
  - `o_lp_stallack` rises 1 cycle after the last beat.
  - Stalled cycles of `i_pl_trdy` or `i_tx_valid` extend this one-for-one.
- **Release:** request drops in cycle M in ACK. `o_lp_stallack=0` and `o_lp_valid` is re-enabled from cycle M+1.
- **Protocol invariants:**
  - `o_lp_stallack` is never high while `o_lp_valid` is high.
  - `o_lp_stallack` is never high while `i_pl_stallreq` is low for more than 1 cycle.
- **`o_stall_abort`:** high for exactly 1 cycle, the cycle after the flit-completing beat.

## Structure
- **Shared package `rdi_pkg`:** the RUN/DRAIN/ACK state encoding (2-bit localparams) and the default FLIT_BEATS.
- **Sub-module `rdi_flit_beat_counter`:**
  - Inputs: `xfer`.
  - Outputs: `beat_cnt`, `at_boundary`, `last_beat`.
  - Reusable by the receive path.
- **FSM and gating:** stay in `rdi_stall_responder`.

## Test plan
All scenarios use FLIT_BEATS=4.
- **Reset:** `sys_rst=1` for 2 cycles with `i_tx_valid=1` and `i_pl_stallreq=1` → `o_lp_stallack=0`, `o_stall_abort=0`. After release at a boundary → ack in 1 cycle.
- **Request at boundary:** idle, request in cycle 10 → `o_lp_valid=0` in cycle 10, `o_lp_stallack=1` at cycle 11. Drop request at 15 → ack=0 and valid resumes at 16.
- **Request mid-flit:** request after beat 1 of a flit (`beat_cnt=1`), trdy held high → exactly 3 more beats, ack 1 cycle after the 4th beat, no new beat afterwards.
- **Draining with backpressure:** request at `beat_cnt=2`, `i_pl_trdy` low for 3 cycles → ack delayed by 3 cycles. `o_lp_stallack` and `o_lp_valid` are never high together.
- **Withdrawn request:** request at `beat_cnt=1`, dropped after 1 cycle → flit completes (4 beats total), `o_stall_abort` pulses 1 cycle, ack never asserts, traffic continues.
- **Reset in DRAIN:** `sys_rst` pulsed at `beat_cnt=2` → next cycle state RUN, counter 0, ack 0. A request then acknowledges in 1 cycle.
